// File: rtl/md_seq.sv
// Iterative multiply/divide sequencer: 32-step shift-add multiply and
// restoring divide, with HI/LO results and a one-cycle write strobe.
module md_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             ready,
    output logic             hilo_we,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        RUN,
        FIX,
        DONE
    } state_t;

    state_t state;
    logic [CW-1:0] cnt;
    logic [1:0] op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] m;
    logic [WIDTH-1:0] p_hi;
    logic [WIDTH-1:0] p_lo;
    logic neg_q;
    logic neg_r;

    logic take;
    logic is_div;
    logic sgn_a;
    logic sgn_b;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH:0] mul_sum;
    logic [WIDTH:0] div_sh;
    logic div_ge;
    logic [WIDTH-1:0] div_rem;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;

    always_comb begin
        take = start && (state == IDLE || state == DONE);
        is_div = op_q[1];
        sgn_a = !op_q[0] && a_q[WIDTH-1];
        sgn_b = !op_q[0] && b_q[WIDTH-1];
        mag_a = sgn_a ? -a_q : a_q;
        mag_b = sgn_b ? -b_q : b_q;
        mul_sum = {1'b0, p_hi} + {1'b0, m};
        // Partial remainder shifted left with the next dividend bit.
        div_sh = {p_hi, p_lo[WIDTH-1]};
        div_ge = div_sh >= {1'b0, m};
        div_rem = div_sh[WIDTH-1:0] - m;
        prod = {p_hi, p_lo};
        prod_fix = neg_q ? -prod : prod;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt <= '0;
            op_q <= '0;
            a_q <= '0;
            b_q <= '0;
            m <= '0;
            p_hi <= '0;
            p_lo <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            hi <= '0;
            lo <= '0;
        end else if (flush) begin
            state <= IDLE;
        end else begin
            if (take) begin
                op_q <= op;
                a_q <= a;
                b_q <= b;
            end
            unique case (state)
                IDLE: begin
                    if (start) state <= PREP;
                end
                PREP: begin
                    m <= is_div ? mag_b : mag_a;
                    p_lo <= is_div ? mag_a : mag_b;
                    p_hi <= '0;
                    neg_q <= sgn_a ^ sgn_b;
                    neg_r <= sgn_a;
                    cnt <= '0;
                    state <= RUN;
                end
                RUN: begin
                    if (is_div) begin
                        p_hi <= div_ge ? div_rem : div_sh[WIDTH-1:0];
                        p_lo <= {p_lo[WIDTH-2:0], div_ge};
                    end else if (p_lo[0]) begin
                        p_hi <= mul_sum[WIDTH:1];
                        p_lo <= {mul_sum[0], p_lo[WIDTH-1:1]};
                    end else begin
                        p_hi <= {1'b0, p_hi[WIDTH-1:1]};
                        p_lo <= {p_hi[0], p_lo[WIDTH-1:1]};
                    end
                    if (cnt == LAST) state <= FIX;
                    else cnt <= cnt + 1'b1;
                end
                FIX: begin
                    // Zero divisor leaves the raw dividend as remainder.
                    if (is_div && m == '0) begin
                        hi <= a_q;
                        lo <= '1;
                    end else if (is_div) begin
                        hi <= neg_r ? -p_hi : p_hi;
                        lo <= neg_q ? -p_lo : p_lo;
                    end else begin
                        {hi, lo} <= prod_fix;
                    end
                    state <= DONE;
                end
                DONE: begin
                    state <= start ? PREP : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state == PREP) || (state == RUN) || (state == FIX);
    assign ready = (state == DONE);
    assign hilo_we = ready;

endmodule
